// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Bundles the hazard inputs and pipeline control outputs exchanged
//            between the MIPS datapath and the pipeline sequencing controller.
// Ports    : id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo  (ID stage)
//            ex_rt, ex_memr, branch_taken                        (EX stage)
//            pc_we, ifid_we, ifid_flush, idex_bubble             (pipe ctl)
//            md_start, md_busy, hilo_we                          (MDU ctl)
//            stall_cnt                                           (stats)
// Modports : master - datapath side (drives hazard info, sinks controls)
//            slave  - controller side
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_md;
  logic             id_reads_hilo;
  logic [REG_W-1:0] ex_rt;
  logic             ex_memr;
  logic             branch_taken;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_start;
  logic             md_busy;
  logic             hilo_we;
  logic [31:0]      stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo,
    output ex_rt, ex_memr, branch_taken,
    input  pc_we, ifid_we, ifid_flush, idex_bubble,
    input  md_start, md_busy, hilo_we, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo,
    input  ex_rt, ex_memr, branch_taken,
    output pc_we, ifid_we, ifid_flush, idex_bubble,
    output md_start, md_busy, hilo_we, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage MIPS core:
//            load-use stalling, taken-branch flushing and issue/occupancy
//            sequencing of the shared multi-cycle MDU with HI/LO write-back.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - pipe_ctrl_if.slave (hazard inputs, pipeline controls,
//                     MDU controls, stall counter)
// Params   : MDU_LAT - cycles from md_start to hilo_we (2..15)
//            REG_W   - register specifier width
// Option   : PIPE_CTRL_STALL_CNT_EN - when defined, builds a saturating
//            32-bit stall-cycle counter; otherwise stall_cnt reads 0.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int REG_W   = 5
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // BUSY lasts MDU_LAT-1 cycles and DONE one more, so hilo_we lands exactly
  // MDU_LAT cycles after the md_start cycle.
  localparam logic [3:0] c_cnt_init = 4'(MDU_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       md_busy_q, md_busy_d;
  logic       hilo_we_q, hilo_we_d;

  logic [REG_W-1:0] w_ex_rt, w_id_rs, w_id_rt;
  logic             w_lu, w_ms, w_md_start;

  assign w_ex_rt = bus.ex_rt;
  assign w_id_rs = bus.id_rs;
  assign w_id_rt = bus.id_rt;

  // Hazard detection. $zero never creates a dependence.
  always_comb begin
    w_lu = bus.ex_memr && (w_ex_rt != '0) &&
           ((w_ex_rt == w_id_rs) || (bus.id_uses_rt && (w_ex_rt == w_id_rt)));
    w_ms = (state_q != ST_IDLE) && (bus.id_is_md || bus.id_reads_hilo);
    // A branch squashes the ID instruction, so it must not launch the MDU.
    w_md_start = rst_n && (state_q == ST_IDLE) && bus.id_is_md &&
                 !bus.branch_taken && !w_lu;
  end

  // Pipeline controls; reset forces the safe "hold + bubble" pattern without
  // waiting for a clock edge.
  always_comb begin
    bus.pc_we       = 1'b1;
    bus.ifid_we     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (!rst_n) begin
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.idex_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (w_lu || w_ms) begin
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.idex_bubble = 1'b1;
    end
  end

  assign bus.md_start = w_md_start;
  assign bus.md_busy  = md_busy_q;
  assign bus.hilo_we  = hilo_we_q;

  // MDU occupancy sequencer. A taken branch does not cancel it: the
  // operation in flight is older than the branch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_md_start) begin
          state_d = ST_BUSY;
          cnt_d   = c_cnt_init;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    md_busy_d = (state_d != ST_IDLE);
    hilo_we_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
      hilo_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      hilo_we_q <= hilo_we_d;
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        w_stall;

  // Load-use and MDU-busy stalls in the same cycle count once.
  always_comb begin
    w_stall     = (w_lu || w_ms) && !bus.branch_taken;
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
